// File: rtl/mc_pkg.sv
// Shared constants for the multicycle main controller: state codes, datapath
// select encodings, instruction classes and the decoded control bundle.
package mc_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       instr_done;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
  } ctrl_t;

  function automatic logic is_legal_state(input logic [3:0] s);
    return (s <= S_BRANCH);
  endfunction

endpackage

// File: rtl/mc_state_decode.sv
// Combinational Moore output decode for the main controller. Only FETCH,
// MEMWR and the undefined-op DECODE exit look at anything beyond the state.
module mc_state_decode
  import mc_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  input  logic [1:0] i_op,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      S_FETCH: begin
        o_ctrl.ir_write   = i_mem_ready;
        o_ctrl.next_pc    = i_mem_ready;
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SRCB_FOUR;
        o_ctrl.result_src = RES_ALU;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SRCB_FOUR;
        o_ctrl.result_src = RES_ALU;
        o_ctrl.instr_done = (i_op == OP_UNDEF);
      end
      S_MEMADR: begin
        o_ctrl.alu_src_b  = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.result_src = RES_RDATA;
        o_ctrl.reg_w      = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        // Write request stays up until memory accepts it.
        o_ctrl.adr_src    = 1'b1;
        o_ctrl.mem_w      = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_EXECUTER: begin
        o_ctrl.alu_src_b  = SRCB_REG;
        o_ctrl.alu_op     = 1'b1;
      end
      S_EXECUTEI: begin
        o_ctrl.alu_src_b  = SRCB_IMM;
        o_ctrl.alu_op     = 1'b1;
      end
      S_ALUWB: begin
        o_ctrl.result_src = RES_ALUOUT;
        o_ctrl.reg_w      = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_b  = SRCB_IMM;
        o_ctrl.result_src = RES_ALU;
        o_ctrl.branch     = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle main controller: state register and next-state logic, with the
// output decode delegated to mc_state_decode.
module mc_main_fsm
  import mc_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       InstrDone,
  output logic [3:0] State
);

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [3:0] w_state_eff;
  logic       w_mem_ready;
  ctrl_t      w_ctrl;
  logic       w_unused_funct;

  assign w_unused_funct = ^Funct[4:1];

  // During reset the outputs look like a stalled FETCH, so no strobe can
  // escape from whatever state was being aborted.
  assign w_state_eff = RESET ? S_FETCH : r_state;
  assign w_mem_ready = MemReady & ~RESET;

  mc_state_decode u_decode (
    .i_state     (w_state_eff),
    .i_mem_ready (w_mem_ready),
    .i_op        (Op),
    .o_ctrl      (w_ctrl)
  );

  always_comb begin
    w_next = S_FETCH;
    if (is_legal_state(r_state)) begin
      unique case (r_state)
        S_FETCH:    w_next = MemReady ? S_DECODE : S_FETCH;
        S_DECODE: begin
          unique case (Op)
            OP_DP:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
            OP_MEM:  w_next = S_MEMADR;
            OP_BR:   w_next = S_BRANCH;
            default: w_next = S_FETCH;
          endcase
        end
        S_MEMADR:   w_next = Funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:    w_next = MemReady ? S_MEMWB : S_MEMRD;
        S_MEMWR:    w_next = MemReady ? S_FETCH : S_MEMWR;
        S_EXECUTER: w_next = S_ALUWB;
        S_EXECUTEI: w_next = S_ALUWB;
        default:    w_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  assign IRWrite   = w_ctrl.ir_write;
  assign NextPC    = w_ctrl.next_pc;
  assign RegW      = w_ctrl.reg_w;
  assign MemW      = w_ctrl.mem_w;
  assign Branch    = w_ctrl.branch;
  assign InstrDone = w_ctrl.instr_done;
  assign AdrSrc    = w_ctrl.adr_src;
  assign ALUSrcA   = w_ctrl.alu_src_a;
  assign ALUSrcB   = w_ctrl.alu_src_b;
  assign ResultSrc = w_ctrl.result_src;
  assign ALUOp     = w_ctrl.alu_op;
  assign State     = w_state_eff;

endmodule
